mem_burst_ctrl: RTL and testbench
=================================

// Module: mem_burst_ctrl
// PURPOSE
//   Burst sequencer directly upstream of the single-port register-file memory.
//   - Accepts one read or write burst command: base address and beat count.
//   - Writes: streams data into the memory write port.
//   - Reads: streams memory contents out with valid/ready backpressure.
//   - Addresses wrap modulo DEPTH.
//   - Drives the memory write_en/addr/data_in pins and samples its combinational data_out.
// PARAMETERS
//   DEPTH  16  memory depth in words; must be a power of 2 (natural address wrap)
//   WIDTH  8   data word width in bits
//   AW     $clog2(DEPTH)  address and length width (localparam, not overridable)
// PORTS
//   clk          in   1      rising-edge clock, single clock domain
//   rst_n        in   1      asynchronous active-low reset
//   cmd_valid    in   1      burst command valid
//   cmd_ready    out  1      command accepted when cmd_valid && cmd_ready
//   cmd_write    in   1      1 = write burst, 0 = read burst
//   cmd_addr     in   AW     first beat address
//   cmd_len      in   AW     beats minus 1 (0 -> 1 beat, DEPTH-1 -> DEPTH beats)
//   wr_valid     in   1      write data beat valid
//   wr_ready     out  1      write beat consumed when wr_valid && wr_ready
//   wr_data      in   WIDTH  write data beat
//   rd_valid     out  1      read data beat valid
//   rd_ready     in   1      read beat consumed when rd_valid && rd_ready
//   rd_data      out  WIDTH  read data beat
//   busy         out  1      high whenever state != IDLE
//   done         out  1      one-cycle pulse: burst complete
//   mem_write_en out  1      to memory write_en
//   mem_addr     out  AW     to memory addr
//   mem_data_in  out  WIDTH  to memory data_in
//   mem_data_out in   WIDTH  from memory data_out (combinational read of mem_addr)
// BEHAVIOUR
//   Reset (async, rst_n low) applies immediately:
//     state=IDLE, cur_addr=0, beats_left=0, rd_valid=0, rd_data=0, done=0.
//     Combinational outputs follow from IDLE: cmd_ready=1, wr_ready=0,
//     mem_write_en=0, mem_addr=0, mem_data_in=wr_data.
//   FSM states: IDLE, WRITE, READ, DRAIN.
//   IDLE
//     - cmd_ready=1.
//     - On handshake: latch cur_addr=cmd_addr and beats_left=cmd_len.
//     - Next state: WRITE if cmd_write=1, otherwise READ.
//   WRITE
//     - Outputs: wr_ready=1; mem_write_en=wr_valid; mem_addr=cur_addr; mem_data_in=wr_data.
//     - On a wr handshake: cur_addr+=1 (wraps DEPTH-1 -> 0) and beats_left-=1.
//     - When the handshake is on the final beat (beats_left==0): go to IDLE and set done=1 next cycle.
//     - wr_valid gaps stall the burst; no write is issued and the address does not change.
//   READ
//     - mem_addr=cur_addr; mem_write_en=0.
//     - Load condition: !rd_valid || rd_ready.
//     - On load: rd_data<=mem_data_out, rd_valid<=1, cur_addr+=1 with wrap, beats_left-=1.
//     - A load on the final beat goes to DRAIN.
//     - If rd_valid && !rd_ready: no load; rd_data and rd_valid are held stable.
//   DRAIN
//     - On rd_valid && rd_ready: rd_valid<=0, go to IDLE, done=1 next cycle.
//   rd_valid is cleared on a rd handshake in any state unless a new beat loads in that same cycle.
//   Latency and throughput
//     - Read: first rd_valid is asserted 2 cycles after the cmd handshake.
//     - Throughput is 1 beat/cycle with rd_ready held high; same for writes.
//   Completion
//     - done is asserted in the same cycle cmd_ready returns high.
//     - A new command may be accepted in that cycle.
//   Commands while busy: cmd_ready=0 and the command is not consumed; the source holds it.
//   Read-after-write: a write in cycle N is visible on a read issued in cycle N+1 or later.
//   Mid-burst reset: the burst is aborted with no further mem_write_en.
//     Beats already written remain, until the memory's own reset clears them.
// TESTING
//   1 wr burst addr=14 len=3, data A0,A1,A2,A3 back-to-back
//     -> mem[14]=A0, mem[15]=A1, mem[0]=A2, mem[1]=A3; done one cycle after beat 4.
//   2 rd burst addr=14 len=3, rd_ready=1
//     -> rd_data A0,A1,A2,A3 on consecutive cycles; first rd_valid 2 cycles after cmd handshake.
//   3 rd burst addr=0 len=7, rd_ready pattern 1,0,1,0...
//     -> 8 beats in address order; none lost or duplicated; rd_data stable while stalled.
//   4 wr burst addr=5 len=2, wr_valid 1,0,0,1,1
//     -> mem_write_en only on the 3 handshake cycles; mem_addr 5,6,7.
//   5 cmd_valid held high during an active burst
//     -> cmd_ready=0 until the done cycle; second command accepted in the done cycle.
//   6 rst_n low after 2 beats of a 4-beat write
//     -> outputs at reset values immediately; cmd_ready=1 after release; no further mem_write_en.

Source files
------------

// File: rtl/mem_burst_ctrl.sv
// mem_burst_ctrl
//   Burst sequencer sitting directly in front of a single-port register-file
//   memory. It accepts one read or write burst command at a time and walks
//   the memory address from cmd_addr for cmd_len+1 beats. The address wraps
//   naturally modulo DEPTH.
//
//   Write bursts stream wr_data beats straight into the memory write port.
//   Read bursts sample the memory's combinational data_out into a one-entry
//   output register with valid/ready backpressure.
//
// Parameters
//   DEPTH  memory depth in words. Must be a power of 2 and at least 2, so the
//          address counter wraps on its own.
//   WIDTH  data word width in bits.
//   AW     address and length width, derived from DEPTH.
//
// Ports
//   clk, rst_n                 clock; asynchronous active-low reset
//   cmd_valid/cmd_ready        burst command handshake
//   cmd_write                  1 = write burst, 0 = read burst
//   cmd_addr                   address of the first beat
//   cmd_len                    number of beats minus one
//   wr_valid/wr_ready/wr_data  write beat stream
//   rd_valid/rd_ready/rd_data  read beat stream (registered)
//   busy                       high whenever a burst is in progress
//   done                       one-cycle pulse when a burst completes
//   mem_write_en               memory write enable
//   mem_addr                   memory address
//   mem_data_in                memory write data
//   mem_data_out               memory read data (combinational read of mem_addr)

module mem_burst_ctrl #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_write,
   input  logic [AW-1:0]    cmd_addr,
   input  logic [AW-1:0]    cmd_len,
   input  logic             wr_valid,
   output logic             wr_ready,
   input  logic [WIDTH-1:0] wr_data,
   output logic             rd_valid,
   input  logic             rd_ready,
   output logic [WIDTH-1:0] rd_data,
   output logic             busy,
   output logic             done,
   output logic             mem_write_en,
   output logic [AW-1:0]    mem_addr,
   output logic [WIDTH-1:0] mem_data_in,
   input  logic [WIDTH-1:0] mem_data_out
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2,
      DRAIN = 2'd3
   } state_t;

   state_t        state;
   state_t        state_next;
   logic [AW-1:0] cur_addr;
   logic [AW-1:0] beats_left;

   logic cmd_fire;
   logic wr_fire;
   logic rd_load;
   logic rd_fire;
   logic last_beat;

   // Handshake and event decode shared by the FSM and the datapath.
   // A read beat is loaded whenever the output register is empty or is
   // being emptied in the same cycle. This keeps one beat per cycle while
   // rd_ready stays high, and holds rd_data stable while the sink stalls.
   always_comb begin
      cmd_fire  = (state == IDLE) && cmd_valid;
      wr_fire   = (state == WRITE) && wr_valid;
      rd_load   = (state == READ) && (!rd_valid || rd_ready);
      rd_fire   = rd_valid && rd_ready;
      last_beat = (beats_left == '0);
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state decode and combinational memory/handshake outputs.
   // The memory address is only driven from cur_addr while a burst touches
   // the memory. Otherwise it rests at zero. A reset therefore takes
   // mem_addr and mem_write_en back to idle values immediately, so an
   // aborted burst cannot issue another write.
   always_comb begin
      state_next   = state;
      cmd_ready    = 1'b0;
      wr_ready     = 1'b0;
      mem_write_en = 1'b0;
      mem_addr     = '0;
      mem_data_in  = wr_data;
      busy         = (state != IDLE);

      case (state)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_fire) begin
               state_next = cmd_write ? WRITE : READ;
            end
         end

         WRITE: begin
            wr_ready     = 1'b1;
            mem_write_en = wr_valid;
            mem_addr     = cur_addr;
            if (wr_fire && last_beat) begin
               state_next = IDLE;
            end
         end

         READ: begin
            mem_addr = cur_addr;
            if (rd_load && last_beat) begin
               state_next = DRAIN;
            end
         end

         DRAIN: begin
            if (rd_fire) begin
               state_next = IDLE;
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Address and beat counters.
   // Both are loaded on command acceptance and stepped on every beat that
   // moves data, whether a write handshake or a read load. The address
   // wraps from DEPTH-1 to 0 because DEPTH is a power of 2.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_addr   <= '0;
         beats_left <= '0;
      end else if (cmd_fire) begin
         cur_addr   <= cmd_addr;
         beats_left <= cmd_len;
      end else if (wr_fire || rd_load) begin
         cur_addr   <= cur_addr + 1'b1;
         beats_left <= beats_left - 1'b1;
      end
   end

   // Read output register.
   // A new load takes priority over clearing. A beat handed off in the same
   // cycle the next one loads leaves rd_valid high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_valid <= 1'b0;
         rd_data  <= '0;
      end else if (rd_load) begin
         rd_valid <= 1'b1;
         rd_data  <= mem_data_out;
      end else if (rd_fire) begin
         rd_valid <= 1'b0;
      end
   end

   // Completion pulse.
   // done is registered, so it is high in the first IDLE cycle after a
   // burst. That is the same cycle cmd_ready returns, and a new command can
   // be accepted then.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done <= 1'b0;
      end else begin
         done <= (wr_fire && last_beat) || ((state == DRAIN) && rd_fire);
      end
   end

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// tb_mem_burst_ctrl
//   Self-checking bench for mem_burst_ctrl.
//   A behavioural register-file memory with a combinational read port is
//   attached to the memory pins. Stimulus tasks push the expected memory
//   writes and read beats into queues as they issue each command, using a
//   shadow copy of the memory contents. A monitor process samples the DUT
//   on the falling edge and pops the queues as beats appear.

module tb_mem_burst_ctrl;

   localparam int DEPTH = 16;
   localparam int WIDTH = 8;
   localparam int AW    = 4;

   logic             clk;
   logic             rst_n;
   logic             cmd_valid;
   logic             cmd_ready;
   logic             cmd_write;
   logic [AW-1:0]    cmd_addr;
   logic [AW-1:0]    cmd_len;
   logic             wr_valid;
   logic             wr_ready;
   logic [WIDTH-1:0] wr_data;
   logic             rd_valid;
   logic             rd_ready;
   logic [WIDTH-1:0] rd_data;
   logic             busy;
   logic             done;
   logic             mem_write_en;
   logic [AW-1:0]    mem_addr;
   logic [WIDTH-1:0] mem_data_in;
   logic [WIDTH-1:0] mem_data_out;

   int check_count = 0;
   int error_count = 0;

   logic [WIDTH-1:0] mem     [DEPTH];
   logic [WIDTH-1:0] exp_mem [DEPTH];
   logic [WIDTH-1:0] rd_q[$];
   logic [AW-1:0]    wr_addr_q[$];
   logic [WIDTH-1:0] wr_data_q[$];

   mem_burst_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_write    (cmd_write),
      .cmd_addr     (cmd_addr),
      .cmd_len      (cmd_len),
      .wr_valid     (wr_valid),
      .wr_ready     (wr_ready),
      .wr_data      (wr_data),
      .rd_valid     (rd_valid),
      .rd_ready     (rd_ready),
      .rd_data      (rd_data),
      .busy         (busy),
      .done         (done),
      .mem_write_en (mem_write_en),
      .mem_addr     (mem_addr),
      .mem_data_in  (mem_data_in),
      .mem_data_out (mem_data_out)
   );

   // Clock generation.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Register-file memory: synchronous write, combinational read.
   always @(posedge clk) begin
      if (mem_write_en) begin
         mem[mem_addr] <= mem_data_in;
      end
   end
   assign mem_data_out = mem[mem_addr];

   // Single comparison point; every check goes through here.
   task automatic check_output(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
      check_count++;
      if (actual !== expected) begin
         error_count++;
         $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Monitor: compare read beats and memory writes against the queues.
   // While a read beat is stalled, the head of the queue is compared again
   // each cycle. This checks that the held rd_data stays correct.
   always @(negedge clk) begin
      if (rst_n && rd_valid) begin
         if (rd_q.size() == 0) begin
            check_output("rd_unexpected", rd_valid, 0);
         end else begin
            check_output("rd_data", rd_data, rd_q[0]);
            if (rd_ready) begin
               void'(rd_q.pop_front());
            end
         end
      end
      if (mem_write_en) begin
         if (wr_addr_q.size() == 0) begin
            check_output("write_unexpected", mem_write_en, 0);
         end else begin
            check_output("mem_addr", mem_addr, wr_addr_q[0]);
            check_output("mem_data_in", mem_data_in, wr_data_q[0]);
            void'(wr_addr_q.pop_front());
            void'(wr_data_q.pop_front());
         end
      end
   end

   // Watchdog so that the run always ends.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog timeout");
      $fatal(1, "[TB] watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a command and hold it until it is accepted (bounded).
   // The task returns 1 time unit after the accepting edge.
   task automatic issue_cmd(input logic wr, input logic [AW-1:0] addr,
                            input logic [AW-1:0] len);
      bit hs = 1'b0;
      int n  = 0;
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_addr  = addr;
      cmd_len   = len;
      while (!hs && n < 50) begin
         @(negedge clk);
         hs = cmd_ready;
         tick();
         n++;
      end
      cmd_valid = 1'b0;
      check_output("cmd_accept", hs, 1);
   endtask

   // Write burst. Beat data is base+i; bit k of pat gives wr_valid in cycle k.
   task automatic write_burst(input logic [AW-1:0] addr, input logic [AW-1:0] len,
                              input logic [WIDTH-1:0] base, input logic [15:0] pat,
                              input int plen);
      int beats = int'(len) + 1;
      int sent  = 0;
      int k     = 0;
      bit fire;
      for (int i = 0; i < beats; i++) begin
         exp_mem[addr + AW'(i)] = base + WIDTH'(i);
         wr_addr_q.push_back(addr + AW'(i));
         wr_data_q.push_back(base + WIDTH'(i));
      end
      issue_cmd(1'b1, addr, len);
      while (sent < beats && k < 200) begin
         wr_valid = pat[k % plen];
         wr_data  = base + WIDTH'(sent);
         @(negedge clk);
         fire = wr_valid && wr_ready;
         check_output("wr_ready", wr_ready, 1);
         check_output("busy_write", busy, 1);
         if (!wr_valid) begin
            check_output("gap_no_write", mem_write_en, 0);
         end
         tick();
         if (fire) begin
            sent++;
         end
         k++;
      end
      wr_valid = 1'b0;
      check_output("write_beats", sent, beats);
      @(negedge clk);
      check_output("write_done", done, 1);
      check_output("write_done_cmd_ready", cmd_ready, 1);
      tick();
      check_output("done_one_cycle", done, 0);
   endtask

   // Read burst. Bit k of pat gives rd_ready in cycle k after acceptance.
   // consec=1 also checks that the last beat lands exactly beats cycles in.
   task automatic read_burst(input logic [AW-1:0] addr, input logic [AW-1:0] len,
                             input logic [15:0] pat, input int plen, input bit consec);
      int beats = int'(len) + 1;
      int got   = 0;
      int k     = 0;
      int last  = -1;
      for (int i = 0; i < beats; i++) begin
         rd_q.push_back(exp_mem[addr + AW'(i)]);
      end
      issue_cmd(1'b0, addr, len);
      while (got < beats && k < 300) begin
         rd_ready = pat[k % plen];
         @(negedge clk);
         if (k == 0) check_output("rd_latency_cycle1", rd_valid, 0);
         if (k == 1) check_output("rd_latency_cycle2", rd_valid, 1);
         check_output("cmd_ready_busy", cmd_ready, 0);
         if (rd_valid && rd_ready) begin
            got++;
            last = k;
         end
         tick();
         k++;
      end
      rd_ready = 1'b0;
      check_output("read_beats", got, beats);
      if (consec) begin
         check_output("read_last_cycle", last, beats);
      end
      @(negedge clk);
      check_output("read_done", done, 1);
      check_output("read_done_cmd_ready", cmd_ready, 1);
      check_output("read_done_rd_valid", rd_valid, 0);
      tick();
   endtask

   initial begin
      int n;
      bit seen;
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = '0;
      cmd_len   = '0;
      wr_valid  = 1'b0;
      wr_data   = 8'h5A;
      rd_ready  = 1'b0;
      #1;
      $display("[TB] reset state");
      check_output("rst_cmd_ready", cmd_ready, 1);
      check_output("rst_wr_ready", wr_ready, 0);
      check_output("rst_rd_valid", rd_valid, 0);
      check_output("rst_rd_data", rd_data, 0);
      check_output("rst_done", done, 0);
      check_output("rst_busy", busy, 0);
      check_output("rst_mem_write_en", mem_write_en, 0);
      check_output("rst_mem_addr", mem_addr, 0);
      check_output("rst_mem_data_in", mem_data_in, 8'h5A);
      repeat (3) tick();
      rst_n = 1'b1;
      tick();

      $display("[TB] preload full memory");
      write_burst(4'd0, 4'd15, 8'h30, 16'hFFFF, 16);

      $display("[TB] test 1: wrapping write burst");
      write_burst(4'd14, 4'd3, 8'hA0, 16'hFFFF, 16);

      $display("[TB] test 2: wrapping read burst, rd_ready high");
      read_burst(4'd14, 4'd3, 16'hFFFF, 16, 1'b1);

      $display("[TB] test 3: read burst with rd_ready 1,0,1,0");
      read_burst(4'd0, 4'd7, 16'h0001, 2, 1'b0);

      $display("[TB] test 4: write burst with wr_valid gaps");
      write_burst(4'd5, 4'd2, 8'h51, 16'h0019, 5);
      read_burst(4'd4, 4'd4, 16'hFFFF, 16, 1'b1);

      $display("[TB] test 5: command held while busy");
      exp_mem[8] = 8'hC0;
      exp_mem[9] = 8'hC1;
      wr_addr_q.push_back(4'd8);
      wr_data_q.push_back(8'hC0);
      wr_addr_q.push_back(4'd9);
      wr_data_q.push_back(8'hC1);
      issue_cmd(1'b1, 4'd8, 4'd1);
      cmd_valid = 1'b1;
      cmd_write = 1'b0;
      cmd_addr  = 4'd8;
      cmd_len   = 4'd1;
      rd_q.push_back(8'hC0);
      rd_q.push_back(8'hC1);
      rd_ready = 1'b1;
      wr_valid = 1'b1;
      wr_data  = 8'hC0;
      @(negedge clk);
      check_output("held_cmd_ready_beat1", cmd_ready, 0);
      check_output("held_done_beat1", done, 0);
      tick();
      wr_data = 8'hC1;
      @(negedge clk);
      check_output("held_cmd_ready_beat2", cmd_ready, 0);
      tick();
      wr_valid = 1'b0;
      @(negedge clk);
      check_output("held_done", done, 1);
      check_output("held_cmd_ready_done", cmd_ready, 1);
      tick();
      cmd_valid = 1'b0;
      @(negedge clk);
      check_output("held_cmd_consumed", cmd_ready, 0);
      check_output("held_busy", busy, 1);
      seen = 1'b0;
      n = 0;
      while (!seen && n < 20) begin
         tick();
         @(negedge clk);
         seen = done;
         n++;
      end
      check_output("held_read_done", seen, 1);
      tick();
      rd_ready = 1'b0;

      $display("[TB] test 6: reset in the middle of a write burst");
      exp_mem[10] = 8'hD0;
      exp_mem[11] = 8'hD1;
      wr_addr_q.push_back(4'd10);
      wr_data_q.push_back(8'hD0);
      wr_addr_q.push_back(4'd11);
      wr_data_q.push_back(8'hD1);
      issue_cmd(1'b1, 4'd10, 4'd3);
      wr_valid = 1'b1;
      wr_data  = 8'hD0;
      tick();
      wr_data = 8'hD1;
      tick();
      wr_data = 8'hD2;
      #2;
      rst_n = 1'b0;
      #1;
      check_output("abort_cmd_ready", cmd_ready, 1);
      check_output("abort_wr_ready", wr_ready, 0);
      check_output("abort_mem_write_en", mem_write_en, 0);
      check_output("abort_mem_addr", mem_addr, 0);
      check_output("abort_busy", busy, 0);
      check_output("abort_done", done, 0);
      check_output("abort_rd_valid", rd_valid, 0);
      check_output("abort_mem_data_in", mem_data_in, 8'hD2);
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check_output("post_reset_cmd_ready", cmd_ready, 1);
         check_output("post_reset_no_write", mem_write_en, 0);
         tick();
      end
      wr_valid = 1'b0;
      read_burst(4'd10, 4'd3, 16'hFFFF, 16, 1'b1);

      repeat (2) tick();
      check_output("rd_queue_empty", rd_q.size(), 0);
      check_output("wr_queue_empty", wr_addr_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", check_count, error_count);
      $finish;
   end

endmodule
